// File: rtl/power_frame_integrator_if.sv
// Stream bundle for the frame power integrator.
// Optional peak outputs exist only with POWER_INT_PEAK_EN.
interface power_frame_integrator_if #(
   parameter int DIN_WIDTH    = 33,
   parameter int ACC_LEN_LOG2 = 10
);
   localparam int DOUT_WIDTH = DIN_WIDTH + ACC_LEN_LOG2;

   logic [DIN_WIDTH-1:0]  din;
   logic                  din_valid;
   logic                  sync_in;
   logic [DOUT_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  frame_err;
`ifdef POWER_INT_PEAK_EN
   logic [DIN_WIDTH-1:0]    peak_val;
   logic [ACC_LEN_LOG2-1:0] peak_idx;

   modport master (
      output din, din_valid, sync_in,
      input  dout, dout_valid, frame_err,
      input  peak_val, peak_idx
   );
   modport slave (
      input  din, din_valid, sync_in,
      output dout, dout_valid, frame_err,
      output peak_val, peak_idx
   );
`else
   modport master (
      output din, din_valid, sync_in,
      input  dout, dout_valid, frame_err
   );
   modport slave (
      input  din, din_valid, sync_in,
      output dout, dout_valid, frame_err
   );
`endif
endinterface

// File: rtl/power_frame_integrator.sv
// Sums 2^ACC_LEN_LOG2 valid power samples per sync-aligned frame.
// Macro POWER_INT_PEAK_EN adds per-frame peak value/index outputs.
module power_frame_integrator #(
   parameter int DIN_WIDTH    = 33,
   parameter int ACC_LEN_LOG2 = 10
) (
   input logic                     clk,
   input logic                     rst,
   power_frame_integrator_if.slave bus
);
   localparam int DOUT_WIDTH = DIN_WIDTH + ACC_LEN_LOG2;
   localparam logic [ACC_LEN_LOG2-1:0] CNT_ONE  = ACC_LEN_LOG2'(1);
   localparam logic [ACC_LEN_LOG2-1:0] CNT_LAST = '1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                  state_q, state_d;
   logic [DOUT_WIDTH-1:0]   acc_q, acc_d;
   logic [ACC_LEN_LOG2-1:0] cnt_q, cnt_d;
   logic [DOUT_WIDTH-1:0]   dout_q, dout_d;
   logic                    dout_valid_q, dout_valid_d;
   logic                    frame_err_q, frame_err_d;

   logic [DOUT_WIDTH-1:0]   din_ext;
   logic [DOUT_WIDTH-1:0]   acc_sum;
   logic                    first_s, mid_s, last_s, err_s, start_s;

   assign din_ext = {{ACC_LEN_LOG2{1'b0}}, bus.din};
   assign acc_sum = acc_q + din_ext;
   assign start_s = first_s | err_s;

   // Classify the current sample: frame start, middle, last, or resync.
   always_comb begin
      first_s = 1'b0;
      mid_s   = 1'b0;
      last_s  = 1'b0;
      err_s   = 1'b0;
      priority case (1'b1)
         !bus.din_valid:               ;
         state_q == IDLE:              first_s = bus.sync_in;
         bus.sync_in && cnt_q != '0:   err_s   = 1'b1;
         cnt_q == '0:                  first_s = 1'b1;
         cnt_q == CNT_LAST:            last_s  = 1'b1;
         default:                      mid_s   = 1'b1;
      endcase
   end

   // Next-state for the accumulator, counter and frame outputs.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      dout_d       = dout_q;
      dout_valid_d = last_s;
      frame_err_d  = err_s;
      if (start_s) begin
         state_d = RUN;
         acc_d   = din_ext;
         cnt_d   = CNT_ONE;
      end else if (mid_s) begin
         acc_d = acc_sum;
         cnt_d = cnt_q + CNT_ONE;
      end else if (last_s) begin
         acc_d  = '0;
         cnt_d  = '0;
         dout_d = acc_sum;
      end
   end

`ifdef POWER_INT_PEAK_EN
   logic [DIN_WIDTH-1:0]    pk_val_q, pk_val_d;
   logic [ACC_LEN_LOG2-1:0] pk_idx_q, pk_idx_d;
   logic [DIN_WIDTH-1:0]    peak_val_q, peak_val_d;
   logic [ACC_LEN_LOG2-1:0] peak_idx_q, peak_idx_d;
   logic                    new_max;

   // Strict compare keeps the first occurrence on ties.
   assign new_max = bus.din > pk_val_q;

   // Running peak; published only when a frame completes.
   always_comb begin
      pk_val_d   = pk_val_q;
      pk_idx_d   = pk_idx_q;
      peak_val_d = peak_val_q;
      peak_idx_d = peak_idx_q;
      if (start_s) begin
         pk_val_d = bus.din;
         pk_idx_d = '0;
      end else if (mid_s && new_max) begin
         pk_val_d = bus.din;
         pk_idx_d = cnt_q;
      end else if (last_s) begin
         pk_val_d   = '0;
         pk_idx_d   = '0;
         peak_val_d = new_max ? bus.din : pk_val_q;
         peak_idx_d = new_max ? cnt_q : pk_idx_q;
      end
   end

   assign bus.peak_val = peak_val_q;
   assign bus.peak_idx = peak_idx_q;
`endif

   // Frame FSM and registered outputs; reset wins over any sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef POWER_INT_PEAK_EN
         pk_val_q     <= '0;
         pk_idx_q     <= '0;
         peak_val_q   <= '0;
         peak_idx_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         frame_err_q  <= frame_err_d;
`ifdef POWER_INT_PEAK_EN
         pk_val_q     <= pk_val_d;
         pk_idx_q     <= pk_idx_d;
         peak_val_q   <= peak_val_d;
         peak_idx_q   <= peak_idx_d;
`endif
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_power_frame_integrator.sv
// Scoreboard bench for power_frame_integrator.
// Peak checks are built only with POWER_INT_PEAK_EN.
module tb_power_frame_integrator;
   localparam int DW  = 33;
   localparam int NS  = 2;
   localparam int NL  = 10;
   localparam int OWS = DW + NS;
   localparam int OWL = DW + NL;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   power_frame_integrator_if #(.DIN_WIDTH(DW), .ACC_LEN_LOG2(NS)) bs ();
   power_frame_integrator_if #(.DIN_WIDTH(DW), .ACC_LEN_LOG2(NL)) bl ();

   power_frame_integrator #(.DIN_WIDTH(DW), .ACC_LEN_LOG2(NS)) u_s (
      .clk(clk), .rst(rst), .bus(bs)
   );
   power_frame_integrator #(.DIN_WIDTH(DW), .ACC_LEN_LOG2(NL)) u_l (
      .clk(clk), .rst(rst), .bus(bl)
   );

   int checks   = 0;
   int failures = 0;
   int cyc_n    = 0;
   int fe_cnt   = 0;

   logic [OWS-1:0] exp_q[$];
   logic [OWS-1:0] got_q[$];
   int             dvc_q[$];
`ifdef POWER_INT_PEAK_EN
   logic [DW-1:0]  pv_q[$];
   logic [NS-1:0]  pi_q[$];
`endif

   // One clock on the small DUT; outputs sampled 1 time unit after the edge.
   task automatic cyc(input logic v, input logic s, input logic [DW-1:0] d);
      bs.din_valid = v;
      bs.sync_in   = s;
      bs.din       = d;
      @(posedge clk);
      #1;
      cyc_n++;
      if (bs.dout_valid === 1'b1) begin
         got_q.push_back(bs.dout);
         dvc_q.push_back(cyc_n);
`ifdef POWER_INT_PEAK_EN
         pv_q.push_back(bs.peak_val);
         pi_q.push_back(bs.peak_idx);
`endif
      end
      if (bs.frame_err === 1'b1) fe_cnt++;
   endtask

   task automatic clear_sb();
      exp_q.delete();
      got_q.delete();
      dvc_q.delete();
`ifdef POWER_INT_PEAK_EN
      pv_q.delete();
      pi_q.delete();
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(1'b1, 1'b1, 33'd7);
      cyc(1'b0, 1'b0, 33'd0);
      checks++;
      if (bs.dout !== '0) begin
         failures++;
         $display("FAIL reset_dout got=%0d exp=0", bs.dout);
      end
      checks++;
      if (bs.dout_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_dv got=%b exp=0", bs.dout_valid);
      end
      checks++;
      if (bs.frame_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_fe got=%b exp=0", bs.frame_err);
      end
      checks++;
      if (bl.dout !== '0 || bl.dout_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_large got=%0d/%b exp=0/0", bl.dout, bl.dout_valid);
      end
      rst = 1'b0;
      clear_sb();
   endtask

   task automatic test_basic();
      int last_c;
      logic [OWS-1:0] e;
      clear_sb();
      cyc(1'b1, 1'b1, 33'd1);
      cyc(1'b1, 1'b0, 33'd2);
      cyc(1'b1, 1'b0, 33'd3);
      exp_q.push_back(OWS'(10));
      cyc(1'b1, 1'b0, 33'd4);
      last_c = cyc_n;
      repeat (3) cyc(1'b0, 1'b0, 33'd0);
      checks++;
      if (got_q.size() !== 1) begin
         failures++;
         $display("FAIL basic_count got=%0d exp=1", got_q.size());
      end
      if (got_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q[0] !== e) begin
            failures++;
            $display("FAIL basic_sum got=%0d exp=%0d", got_q[0], e);
         end
         checks++;
         if (dvc_q[0] !== last_c) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=%0d", dvc_q[0], last_c);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [OWS-1:0] e;
      logic [DW-1:0] f1 [4];
      f1 = '{33'd1, 33'd2, 33'd3, 33'd4};
      clear_sb();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) exp_q.push_back(OWS'(10));
         cyc(1'b1, i == 0, f1[i]);
      end
      for (int i = 0; i < 4; i++) begin
         if (i == 3) exp_q.push_back(OWS'(20));
         cyc(1'b1, 1'b0, 33'd5);
      end
      repeat (2) cyc(1'b0, 1'b0, 33'd0);
      checks++;
      if (got_q.size() !== 2) begin
         failures++;
         $display("FAIL b2b_count got=%0d exp=2", got_q.size());
      end
      if (got_q.size() == 2) begin
         checks++;
         if (dvc_q[1] - dvc_q[0] !== 4) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d exp=4", dvc_q[1] - dvc_q[0]);
         end
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q[0] !== e) begin
            failures++;
            $display("FAIL b2b_sum got=%0d exp=%0d", got_q[0], e);
         end
         void'(got_q.pop_front());
      end
      checks++;
      if (bs.dout !== OWS'(20)) begin
         failures++;
         $display("FAIL b2b_hold got=%0d exp=20", bs.dout);
      end
   endtask

   task automatic test_gaps();
      int last_c;
      logic [OWS-1:0] e;
      clear_sb();
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) exp_q.push_back(OWS'(10));
         cyc(1'b1, i == 1, DW'(i));
         if (i == 4) last_c = cyc_n;
         else repeat (3) cyc(1'b0, 1'b0, 33'd99);
      end
      repeat (2) cyc(1'b0, 1'b0, 33'd0);
      checks++;
      if (got_q.size() !== 1) begin
         failures++;
         $display("FAIL gaps_count got=%0d exp=1", got_q.size());
      end
      if (got_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q[0] !== e || dvc_q[0] !== last_c) begin
            failures++;
            $display("FAIL gaps_sum got=%0d@%0d exp=%0d@%0d",
                     got_q[0], dvc_q[0], e, last_c);
         end
      end
   endtask

   task automatic test_mid_sync();
      int fe0;
      logic [OWS-1:0] e;
      clear_sb();
      fe0 = fe_cnt;
      cyc(1'b1, 1'b1, 33'd7);
      cyc(1'b1, 1'b0, 33'd7);
      cyc(1'b1, 1'b1, 33'd1);
      cyc(1'b1, 1'b0, 33'd1);
      cyc(1'b1, 1'b0, 33'd1);
      exp_q.push_back(OWS'(4));
      cyc(1'b1, 1'b0, 33'd1);
      repeat (2) cyc(1'b0, 1'b0, 33'd0);
      checks++;
      if (fe_cnt - fe0 !== 1) begin
         failures++;
         $display("FAIL mid_fe_pulses got=%0d exp=1", fe_cnt - fe0);
      end
      checks++;
      if (got_q.size() !== 1) begin
         failures++;
         $display("FAIL mid_count got=%0d exp=1", got_q.size());
      end
      if (got_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q[0] !== e) begin
            failures++;
            $display("FAIL mid_sum got=%0d exp=%0d", got_q[0], e);
         end
      end
   endtask

   task automatic test_reset_mid();
      int fe0;
      logic [OWS-1:0] e;
      clear_sb();
      cyc(1'b1, 1'b1, 33'd1);
      cyc(1'b1, 1'b0, 33'd2);
      rst = 1'b1;
      cyc(1'b1, 1'b0, 33'd3);
      rst = 1'b0;
      checks++;
      if (bs.dout !== '0 || bs.dout_valid !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_clear got=%0d/%b exp=0/0", bs.dout, bs.dout_valid);
      end
      fe0 = fe_cnt;
      repeat (4) cyc(1'b1, 1'b0, 33'd1);
      repeat (4) cyc(1'b1, 1'b0, 33'd1);
      repeat (2) cyc(1'b0, 1'b0, 33'd0);
      checks++;
      if (got_q.size() !== 0 || fe_cnt !== fe0) begin
         failures++;
         $display("FAIL rstmid_idle got=%0d/%0d exp=0/0", got_q.size(), fe_cnt - fe0);
      end
      for (int i = 0; i < 4; i++) begin
         if (i == 3) exp_q.push_back(OWS'(8));
         cyc(1'b1, i == 0, 33'd2);
      end
      cyc(1'b0, 1'b0, 33'd0);
      checks++;
      if (got_q.size() !== 1) begin
         failures++;
         $display("FAIL rstmid_count got=%0d exp=1", got_q.size());
      end
      if (got_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q[0] !== e) begin
            failures++;
            $display("FAIL rstmid_sum got=%0d exp=%0d", got_q[0], e);
         end
      end
   endtask

   task automatic test_wide();
      logic [OWL-1:0] wexp_q[$];
      logic [OWL-1:0] e;
      logic [OWL-1:0] ones;
      int early;
      int dv_last;
      early   = 0;
      dv_last = 0;
      ones    = {{NL{1'b0}}, {DW{1'b1}}};
      for (int i = 0; i < 1024; i++) begin
         if (i == 1023) wexp_q.push_back(ones * OWL'(1024));
         bl.din_valid = 1'b1;
         bl.sync_in   = (i == 0);
         bl.din       = {DW{1'b1}};
         @(posedge clk);
         #1;
         if (bl.dout_valid === 1'b1) begin
            if (i == 1023) dv_last = 1;
            else early++;
         end
      end
      bl.din_valid = 1'b0;
      bl.sync_in   = 1'b0;
      checks++;
      if (early !== 0 || dv_last !== 1) begin
         failures++;
         $display("FAIL wide_pulse got=%0d/%0d exp=0/1", early, dv_last);
      end
      e = wexp_q.pop_front();
      checks++;
      if (bl.dout !== e) begin
         failures++;
         $display("FAIL wide_sum got=%0d exp=%0d", bl.dout, e);
      end
   endtask

`ifdef POWER_INT_PEAK_EN
   task automatic test_peak();
      logic [DW-1:0] f [4];
      f = '{33'd3, 33'd9, 33'd9, 33'd2};
      clear_sb();
      for (int i = 0; i < 4; i++) cyc(1'b1, i == 0, f[i]);
      cyc(1'b0, 1'b0, 33'd0);
      checks++;
      if (got_q.size() !== 1) begin
         failures++;
         $display("FAIL peak_count got=%0d exp=1", got_q.size());
      end else begin
         checks++;
         if (got_q[0] !== OWS'(23) || pv_q[0] !== DW'(9) || pi_q[0] !== NS'(1)) begin
            failures++;
            $display("FAIL peak_frame got=%0d/%0d/%0d exp=23/9/1",
                     got_q[0], pv_q[0], pi_q[0]);
         end
      end
      clear_sb();
      cyc(1'b1, 1'b1, 33'd50);
      cyc(1'b1, 1'b1, 33'd1);
      cyc(1'b1, 1'b0, 33'd1);
      cyc(1'b1, 1'b0, 33'd4);
      cyc(1'b1, 1'b0, 33'd1);
      cyc(1'b0, 1'b0, 33'd0);
      checks++;
      if (got_q.size() !== 1) begin
         failures++;
         $display("FAIL peak_drop_count got=%0d exp=1", got_q.size());
      end else begin
         checks++;
         if (got_q[0] !== OWS'(7) || pv_q[0] !== DW'(4) || pi_q[0] !== NS'(2)) begin
            failures++;
            $display("FAIL peak_drop got=%0d/%0d/%0d exp=7/4/2",
                     got_q[0], pv_q[0], pi_q[0]);
         end
      end
   endtask
`endif

   initial begin
      bs.din       = '0;
      bs.din_valid = 1'b0;
      bs.sync_in   = 1'b0;
      bl.din       = '0;
      bl.din_valid = 1'b0;
      bl.sync_in   = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_gaps();
      test_mid_sync();
      test_reset_mid();
      test_wide();
`ifdef POWER_INT_PEAK_EN
      test_peak();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
